// File: rtl/hazard_ctrl.sv
// Interlock and forwarding controller for the 5-stage core, with the mult/div busy window.
// Define HAZ_FWD_EN for Tnew/Tuse forwarding; left undefined, every RAW match stalls and all selects stay at RF.
module hazard_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10,
    parameter int unsigned CNT_W       = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [4:0] d_rs,
    input  logic [4:0] d_rt,
    input  logic [1:0] d_tuse_rs,
    input  logic [1:0] d_tuse_rt,
    input  logic [4:0] d_wa,
    input  logic [1:0] d_tnew,
    input  logic       d_md_use,
    input  logic       d_md_start,
    input  logic       d_md_div,
    output logic       stall,
    output logic [1:0] fwd_d_rs,
    output logic [1:0] fwd_d_rt,
    output logic [1:0] fwd_e_rs,
    output logic [1:0] fwd_e_rt,
    output logic       md_busy
);

    localparam logic [1:0] SEL_RF    = 2'd0;
    localparam logic [1:0] TUSE_NONE = 2'd3;

    logic [4:0]       e_wa_q, e_wa_d;
    logic [1:0]       e_tnew_q, e_tnew_d;
    logic [4:0]       e_rs_q, e_rs_d;
    logic [4:0]       e_rt_q, e_rt_d;
    logic             e_md_start_q, e_md_start_d;
    logic             e_md_div_q, e_md_div_d;
    logic [4:0]       m_wa_q, m_wa_d;
    logic [1:0]       m_tnew_q, m_tnew_d;
    logic [4:0]       w_wa_q, w_wa_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic rs_used, rt_used;
    logic rs_haz, rt_haz, md_haz;

    assign rs_used = (d_tuse_rs != TUSE_NONE) && (d_rs != 5'd0);
    assign rt_used = (d_tuse_rt != TUSE_NONE) && (d_rt != 5'd0);

`ifdef HAZ_FWD_EN
    localparam logic [1:0] SEL_M = 2'd1;
    localparam logic [1:0] SEL_W = 2'd2;

    // M wins over W: it holds the younger write to the same register.
    function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                           input logic [4:0] m_wa,
                                           input logic [1:0] m_tnew,
                                           input logic [4:0] w_wa);
        logic [1:0] sel;
        sel = SEL_RF;
        if (src != 5'd0) begin
            if (m_wa == src && m_tnew == 2'd0) begin
                sel = SEL_M;
            end else if (w_wa == src) begin
                sel = SEL_W;
            end
        end
        return sel;
    endfunction

    assign rs_haz = rs_used &&
                    ((e_wa_q == d_rs && e_tnew_q > d_tuse_rs) ||
                     (m_wa_q == d_rs && m_tnew_q > d_tuse_rs));
    assign rt_haz = rt_used &&
                    ((e_wa_q == d_rt && e_tnew_q > d_tuse_rt) ||
                     (m_wa_q == d_rt && m_tnew_q > d_tuse_rt));

    assign fwd_d_rs = fwd_sel(d_rs,   m_wa_q, m_tnew_q, w_wa_q);
    assign fwd_d_rt = fwd_sel(d_rt,   m_wa_q, m_tnew_q, w_wa_q);
    assign fwd_e_rs = fwd_sel(e_rs_q, m_wa_q, m_tnew_q, w_wa_q);
    assign fwd_e_rt = fwd_sel(e_rt_q, m_wa_q, m_tnew_q, w_wa_q);
`else
    // Without bypass paths a source must wait until its producer has left W.
    assign rs_haz = rs_used && (e_wa_q == d_rs || m_wa_q == d_rs || w_wa_q == d_rs);
    assign rt_haz = rt_used && (e_wa_q == d_rt || m_wa_q == d_rt || w_wa_q == d_rt);

    assign fwd_d_rs = SEL_RF;
    assign fwd_d_rt = SEL_RF;
    assign fwd_e_rs = SEL_RF;
    assign fwd_e_rt = SEL_RF;

    logic unused_fwd_state;
    assign unused_fwd_state = ^{m_tnew_q, e_rs_q, e_rt_q};
`endif

    assign md_busy = (cnt_q != '0);
    assign md_haz  = d_md_use && (md_busy || e_md_start_q);
    assign stall   = rs_haz || rt_haz || md_haz;

    always_comb begin
        w_wa_d   = m_wa_q;
        m_wa_d   = e_wa_q;
        m_tnew_d = (e_tnew_q == 2'd0) ? 2'd0 : e_tnew_q - 2'd1;

        if (stall) begin
            e_wa_d       = '0;
            e_tnew_d     = '0;
            e_rs_d       = '0;
            e_rt_d       = '0;
            e_md_start_d = 1'b0;
            e_md_div_d   = 1'b0;
        end else begin
            e_wa_d       = d_wa;
            e_tnew_d     = d_tnew;
            e_rs_d       = d_rs;
            e_rt_d       = d_rt;
            e_md_start_d = d_md_start;
            e_md_div_d   = d_md_div;
        end

        if (e_md_start_q) begin
            cnt_d = e_md_div_q ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            e_wa_q       <= '0;
            e_tnew_q     <= '0;
            e_rs_q       <= '0;
            e_rt_q       <= '0;
            e_md_start_q <= 1'b0;
            e_md_div_q   <= 1'b0;
            m_wa_q       <= '0;
            m_tnew_q     <= '0;
            w_wa_q       <= '0;
            cnt_q        <= '0;
        end else begin
            e_wa_q       <= e_wa_d;
            e_tnew_q     <= e_tnew_d;
            e_rs_q       <= e_rs_d;
            e_rt_q       <= e_rt_d;
            e_md_start_q <= e_md_start_d;
            e_md_div_q   <= e_md_div_d;
            m_wa_q       <= m_wa_d;
            m_tnew_q     <= m_tnew_d;
            w_wa_q       <= w_wa_d;
            cnt_q        <= cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl; expectations follow whichever HAZ_FWD_EN build is compiled.
module tb_hazard_ctrl;

`ifdef HAZ_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n;
    logic [4:0] d_rs, d_rt, d_wa;
    logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew;
    logic       d_md_use, d_md_start, d_md_div;
    logic       stall, md_busy;
    logic [1:0] fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(
        .MULT_CYCLES(5),
        .DIV_CYCLES (10),
        .CNT_W      (4)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .d_rs      (d_rs),
        .d_rt      (d_rt),
        .d_tuse_rs (d_tuse_rs),
        .d_tuse_rt (d_tuse_rt),
        .d_wa      (d_wa),
        .d_tnew    (d_tnew),
        .d_md_use  (d_md_use),
        .d_md_start(d_md_start),
        .d_md_div  (d_md_div),
        .stall     (stall),
        .fwd_d_rs  (fwd_d_rs),
        .fwd_d_rt  (fwd_d_rt),
        .fwd_e_rs  (fwd_e_rs),
        .fwd_e_rt  (fwd_e_rt),
        .md_busy   (md_busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic d_idle();
        d_rs = '0; d_rt = '0; d_tuse_rs = 2'd3; d_tuse_rt = 2'd3;
        d_wa = '0; d_tnew = '0;
        d_md_use = 1'b0; d_md_start = 1'b0; d_md_div = 1'b0;
    endtask

    task automatic drain();
        d_idle();
        repeat (4) tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        d_idle();
        d_rs = 5'd3; d_tuse_rs = 2'd0;
        repeat (2) tick();
        reset_n = 1'b1;
        #1;
        n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %0b want 0", stall); end
        n_tests++; if (fwd_d_rs !== 2'd0) begin n_fail++; $display("FAIL reset_fwd_d_rs: got %0d want 0", fwd_d_rs); end
        n_tests++; if (fwd_d_rt !== 2'd0) begin n_fail++; $display("FAIL reset_fwd_d_rt: got %0d want 0", fwd_d_rt); end
        n_tests++; if (fwd_e_rs !== 2'd0) begin n_fail++; $display("FAIL reset_fwd_e_rs: got %0d want 0", fwd_e_rs); end
        n_tests++; if (fwd_e_rt !== 2'd0) begin n_fail++; $display("FAIL reset_fwd_e_rt: got %0d want 0", fwd_e_rt); end
        n_tests++; if (md_busy !== 1'b0) begin n_fail++; $display("FAIL reset_md_busy: got %0b want 0", md_busy); end
    endtask

    task automatic test_load_use();
        int nst;
        drain();
        d_wa = 5'd8; d_tnew = 2'd2;
        #1;
        n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL lu_issue_stall: got %0b want 0", stall); end
        tick();
        d_idle();
        d_rs = 5'd8; d_tuse_rs = 2'd0;
        nst = 0;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (stall !== 1'b1) break;
            nst++;
            tick();
        end
        n_tests++; if (nst != (FWD ? 2 : 3)) begin n_fail++; $display("FAIL lu_stall_cycles: got %0d want %0d", nst, FWD ? 2 : 3); end
        n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL lu_stall_release: got %0b want 0", stall); end
        n_tests++; if (fwd_d_rs !== (FWD ? 2'd2 : 2'd0)) begin n_fail++; $display("FAIL lu_fwd_d_rs: got %0d want %0d", fwd_d_rs, FWD ? 2 : 0); end
        tick();
    endtask

    task automatic test_alu_alu();
        int nst;
        drain();
        d_wa = 5'd9; d_tnew = 2'd1;
        #1;
        tick();
        d_idle();
        d_rt = 5'd9; d_tuse_rt = 2'd1;
        nst = 0;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (stall !== 1'b1) break;
            nst++;
            tick();
        end
        n_tests++; if (nst != (FWD ? 0 : 3)) begin n_fail++; $display("FAIL alu_stall_cycles: got %0d want %0d", nst, FWD ? 0 : 3); end
        tick();
        #1;
        n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL alu_stall_next: got %0b want 0", stall); end
        n_tests++; if (fwd_e_rt !== (FWD ? 2'd1 : 2'd0)) begin n_fail++; $display("FAIL alu_fwd_e_rt_m: got %0d want %0d", fwd_e_rt, FWD ? 1 : 0); end
        n_tests++; if (fwd_d_rt !== (FWD ? 2'd1 : 2'd0)) begin n_fail++; $display("FAIL alu_fwd_d_rt_m: got %0d want %0d", fwd_d_rt, FWD ? 1 : 0); end
        tick();
        #1;
        n_tests++; if (fwd_d_rt !== (FWD ? 2'd2 : 2'd0)) begin n_fail++; $display("FAIL alu_fwd_d_rt_w: got %0d want %0d", fwd_d_rt, FWD ? 2 : 0); end
        n_tests++; if (fwd_e_rt !== (FWD ? 2'd2 : 2'd0)) begin n_fail++; $display("FAIL alu_fwd_e_rt_w: got %0d want %0d", fwd_e_rt, FWD ? 2 : 0); end
        d_idle();
        tick();
    endtask

    task automatic test_zero_reg();
        drain();
        d_wa = 5'd0; d_tnew = 2'd2;
        #1;
        tick();
        d_idle();
        d_rs = 5'd0; d_tuse_rs = 2'd0;
        d_rt = 5'd0; d_tuse_rt = 2'd0;
        #1;
        n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL zero_stall: got %0b want 0", stall); end
        n_tests++; if (fwd_d_rs !== 2'd0) begin n_fail++; $display("FAIL zero_fwd_d_rs: got %0d want 0", fwd_d_rs); end
        n_tests++; if (fwd_d_rt !== 2'd0) begin n_fail++; $display("FAIL zero_fwd_d_rt: got %0d want 0", fwd_d_rt); end
        tick();
        #1;
        n_tests++; if (fwd_e_rs !== 2'd0) begin n_fail++; $display("FAIL zero_fwd_e_rs: got %0d want 0", fwd_e_rs); end
        n_tests++; if (fwd_e_rt !== 2'd0) begin n_fail++; $display("FAIL zero_fwd_e_rt: got %0d want 0", fwd_e_rt); end
        d_idle();
        tick();
    endtask

    task automatic test_priority();
        int nst;
        drain();
        d_wa = 5'd5; d_tnew = 2'd1;
        #1;
        tick();
        #1;
        n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL prio_second_write_stall: got %0b want 0", stall); end
        tick();
        d_idle();
        d_rs = 5'd5; d_tuse_rs = 2'd1;
        nst = 0;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (stall !== 1'b1) break;
            nst++;
            tick();
        end
        n_tests++; if (nst != (FWD ? 0 : 3)) begin n_fail++; $display("FAIL prio_stall_cycles: got %0d want %0d", nst, FWD ? 0 : 3); end
        n_tests++; if (fwd_d_rs !== (FWD ? 2'd1 : 2'd0)) begin n_fail++; $display("FAIL prio_fwd_d_rs: got %0d want %0d", fwd_d_rs, FWD ? 1 : 0); end
        tick();
        d_idle();
        #1;
        n_tests++; if (fwd_e_rs !== (FWD ? 2'd1 : 2'd0)) begin n_fail++; $display("FAIL prio_fwd_e_rs: got %0d want %0d", fwd_e_rs, FWD ? 1 : 0); end
        tick();
    endtask

    task automatic test_divide();
        int nb;
        drain();
        d_md_use = 1'b1; d_md_start = 1'b1; d_md_div = 1'b1;
        #1;
        n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL div_issue_stall: got %0b want 0", stall); end
        n_tests++; if (md_busy !== 1'b0) begin n_fail++; $display("FAIL div_issue_busy: got %0b want 0", md_busy); end
        tick();
        d_idle();
        d_md_use = 1'b1;
        #1;
        n_tests++; if (stall !== 1'b1) begin n_fail++; $display("FAIL div_e_start_stall: got %0b want 1", stall); end
        n_tests++; if (md_busy !== 1'b0) begin n_fail++; $display("FAIL div_e_start_busy: got %0b want 0", md_busy); end
        tick();
        nb = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (md_busy !== 1'b1) break;
            nb++;
            n_tests++; if (stall !== 1'b1) begin n_fail++; $display("FAIL div_busy_stall: got %0b want 1 at busy cycle %0d", stall, nb); end
            tick();
        end
        n_tests++; if (nb != 10) begin n_fail++; $display("FAIL div_busy_cycles: got %0d want 10", nb); end
        n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL div_release_stall: got %0b want 0", stall); end
        d_idle();
        tick();
    endtask

    task automatic test_mult();
        int nb;
        drain();
        d_md_use = 1'b1; d_md_start = 1'b1; d_md_div = 1'b0;
        #1;
        tick();
        d_idle();
        tick();
        nb = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (md_busy !== 1'b1) break;
            nb++;
            tick();
        end
        n_tests++; if (nb != 5) begin n_fail++; $display("FAIL mult_busy_cycles: got %0d want 5", nb); end
    endtask

    task automatic test_reset_mid();
        drain();
        d_md_use = 1'b1; d_md_start = 1'b1; d_md_div = 1'b1;
        #1;
        tick();
        d_idle();
        tick();
        #1;
        n_tests++; if (md_busy !== 1'b1) begin n_fail++; $display("FAIL rst_mid_busy_start: got %0b want 1", md_busy); end
        repeat (3) tick();
        d_wa = 5'd7; d_tnew = 2'd2;
        #1;
        tick();
        d_idle();
        d_rs = 5'd7; d_tuse_rs = 2'd0; d_md_use = 1'b1;
        #1;
        n_tests++; if (stall !== 1'b1) begin n_fail++; $display("FAIL rst_mid_pre_stall: got %0b want 1", stall); end
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        #1;
        n_tests++; if (md_busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %0b want 0", md_busy); end
        n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rst_mid_stall: got %0b want 0", stall); end
        n_tests++; if (fwd_d_rs !== 2'd0) begin n_fail++; $display("FAIL rst_mid_fwd_d_rs: got %0d want 0", fwd_d_rs); end
        tick();
        #1;
        n_tests++; if (md_busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy_after: got %0b want 0", md_busy); end
        n_tests++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rst_mid_stall_after: got %0b want 0", stall); end
        d_idle();
        tick();
    endtask

    initial begin
        reset_n = 1'b0;
        d_idle();
        repeat (2) tick();
        test_reset();
        test_load_use();
        test_alu_alu();
        test_zero_reg();
        test_priority();
        test_divide();
        test_mult();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "timeout");
    end

endmodule
